// File: rtl/sseg_scan_controller.sv
// Scan controller for an 8-digit common-anode seven-segment display.
// Walks one active-low anode per refresh slot and presents the matching nibble
// and decimal point. Host updates are double-buffered and only committed at a
// frame boundary, so a frame never mixes old and new digits.
module sseg_scan_controller #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] data_in,
  input  logic        load,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  blank_in,
  input  logic        lz_en,
  output logic [3:0]  hex_out,
  output logic [7:0]  anode,
  output logic        dp_n,
  output logic [2:0]  digit_sel,
  output logic        frame_tick,
  output logic        pending
);

  logic [CNT_W-1:0] cnt;

  logic [31:0] act_data;
  logic [7:0]  act_dp;
  logic [7:0]  act_blank;
  logic        act_lz;

  logic [31:0] pend_data;
  logic [7:0]  pend_dp;
  logic [7:0]  pend_blank;
  logic        pend_lz;

  logic        slot_end;
  logic        frame_end;
  logic [7:0]  zero_from;
  logic [7:0]  dark;

  assign slot_end  = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (digit_sel == 3'd7);

  // Refresh counter and digit index: one slot per REFRESH_DIV clocks.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt       <= '0;
      digit_sel <= 3'd0;
    end else if (slot_end) begin
      cnt       <= '0;
      digit_sel <= digit_sel + 3'd1;
    end else begin
      cnt       <= cnt + CNT_W'(1);
    end
  end

  // Double buffer: loads land in the pending copy, committed only at frame end;
  // a load coinciding with frame end goes straight to the active copy.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      act_data   <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
      act_lz     <= 1'b0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_lz    <= 1'b0;
      pending    <= 1'b0;
    end else if (frame_end) begin
      if (load) begin
        act_data  <= data_in;
        act_dp    <= dp_in;
        act_blank <= blank_in;
        act_lz    <= lz_en;
      end else if (pending) begin
        act_data  <= pend_data;
        act_dp    <= pend_dp;
        act_blank <= pend_blank;
        act_lz    <= pend_lz;
      end
      pending <= 1'b0;
    end else if (load) begin
      pend_data  <= data_in;
      pend_dp    <= dp_in;
      pend_blank <= blank_in;
      pend_lz    <= lz_en;
      pending    <= 1'b1;
    end
  end

  // Per-digit dark mask: forced blank, or a leading zero when suppression is on.
  // Digit 0 is never suppressed so an all-zero word still shows one "0".
  always_comb begin
    zero_from = '0;
    for (int k = 0; k < 8; k++) begin
      zero_from[k] = ((act_data >> (4 * k)) == 32'd0);
    end
    dark = act_blank;
    if (act_lz) begin
      dark = act_blank | {zero_from[7:1], 1'b0};
    end
  end

  // Registered display outputs: all three move together one clock after digit_sel.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hex_out <= 4'd0;
      anode   <= 8'hFF;
      dp_n    <= 1'b1;
    end else begin
      hex_out <= act_data[{digit_sel, 2'b00} +: 4];
      if (dark[digit_sel]) begin
        anode <= 8'hFF;
        dp_n  <= 1'b1;
      end else begin
        anode <= ~(8'b1 << digit_sel);
        dp_n  <= ~act_dp[digit_sel];
      end
    end
  end

  // Frame tick: registered copy of frame_end, high for exactly one clock.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_sseg_scan_controller.sv
// Directed bench for sseg_scan_controller with REFRESH_DIV = 4 (32-clock frames).
// Sample index cyc counts rising edges since reset release, sampled on the
// falling edge; digit k of frame f is on the outputs for cyc 32f+4k .. 32f+4k+3.
module tb_sseg_scan_controller;

  localparam int REFRESH_DIV = 4;
  localparam int CNT_W       = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] data_in;
  logic        load;
  logic [7:0]  dp_in;
  logic [7:0]  blank_in;
  logic        lz_en;
  logic [3:0]  hex_out;
  logic [7:0]  anode;
  logic        dp_n;
  logic [2:0]  digit_sel;
  logic        frame_tick;
  logic        pending;

  typedef struct {
    int          c;
    logic [31:0] d;
    logic [7:0]  dp;
    logic [7:0]  bl;
    logic        lz;
  } load_t;

  typedef struct {
    int   c;
    logic v;
  } pend_t;

  load_t load_q[$];
  pend_t pend_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = -1;

  // Expected per-frame picture: anode byte, nibble and dp_n bit per digit k.
  logic [63:0] exp_anodes;
  logic [31:0] exp_hex;
  logic [7:0]  exp_dpn;

  localparam logic [63:0] NORMAL_ANODES = 64'h7FBF_DFEF_F7FB_FDFE;

  always #5 clk = ~clk;

  sseg_scan_controller #(
    .REFRESH_DIV(REFRESH_DIV),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .data_in   (data_in),
    .load      (load),
    .dp_in     (dp_in),
    .blank_in  (blank_in),
    .lz_en     (lz_en),
    .hex_out   (hex_out),
    .anode     (anode),
    .dp_n      (dp_n),
    .digit_sel (digit_sel),
    .frame_tick(frame_tick),
    .pending   (pending)
  );

  // Single comparison point: counts every vector and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ".anode"},      64'(anode),      64'hFF);
    checkOutput({tag, ".hex"},        64'(hex_out),    64'h0);
    checkOutput({tag, ".dp_n"},       64'(dp_n),       64'h1);
    checkOutput({tag, ".digit_sel"},  64'(digit_sel),  64'h0);
    checkOutput({tag, ".frame_tick"}, 64'(frame_tick), 64'h0);
    checkOutput({tag, ".pending"},    64'(pending),    64'h0);
  endtask

  // Drives any load scheduled right after sample cyc; captured on the next edge.
  task automatic applyStimulus();
    load = 1'b0;
    foreach (load_q[i]) begin
      if (load_q[i].c == cyc) begin
        load     = 1'b1;
        data_in  = load_q[i].d;
        dp_in    = load_q[i].dp;
        blank_in = load_q[i].bl;
        lz_en    = load_q[i].lz;
      end
    end
  endtask

  task automatic runTo(input int last);
    int slot;
    while (cyc < last) begin
      tick();
      slot = (cyc / 4) % 8;
      checkOutput($sformatf("anode.d%0d", slot), 64'(anode),      64'(exp_anodes[slot*8 +: 8]));
      checkOutput($sformatf("hex.d%0d", slot),   64'(hex_out),    64'(exp_hex[slot*4 +: 4]));
      checkOutput($sformatf("dp_n.d%0d", slot),  64'(dp_n),       64'(exp_dpn[slot]));
      checkOutput("digit_sel",                   64'(digit_sel),  64'(((cyc + 1) / 4) % 8));
      checkOutput("frame_tick",                  64'(frame_tick), 64'((cyc % 32) == 31));
      foreach (pend_q[i]) begin
        if (pend_q[i].c == cyc) begin
          checkOutput("pending", 64'(pending), 64'(pend_q[i].v));
        end
      end
      applyStimulus();
    end
  endtask

  task automatic setFrame(input logic [63:0] a, input logic [31:0] h, input logic [7:0] d);
    exp_anodes = a;
    exp_hex    = h;
    exp_dpn    = d;
  endtask

  initial begin
    reset_n  = 1'b0;
    data_in  = 32'd0;
    load     = 1'b0;
    dp_in    = 8'd0;
    blank_in = 8'd0;
    lz_en    = 1'b0;

    load_q.push_back(load_t'{45,  32'h1234_5678, 8'h00, 8'h00, 1'b0});
    load_q.push_back(load_t'{70,  32'h0000_A05C, 8'h04, 8'h00, 1'b1});
    load_q.push_back(load_t'{100, 32'h0000_0000, 8'h00, 8'h00, 1'b1});
    load_q.push_back(load_t'{140, 32'h8765_4321, 8'h00, 8'hFF, 1'b0});
    load_q.push_back(load_t'{170, 32'h1111_1111, 8'h00, 8'h00, 1'b0});
    load_q.push_back(load_t'{190, 32'h2222_2222, 8'h00, 8'h00, 1'b0});
    load_q.push_back(load_t'{230, 32'h3333_3333, 8'h00, 8'h00, 1'b0});

    pend_q.push_back(pend_t'{46,  1'b1});
    pend_q.push_back(pend_t'{62,  1'b1});
    pend_q.push_back(pend_t'{63,  1'b0});
    pend_q.push_back(pend_t'{71,  1'b1});
    pend_q.push_back(pend_t'{95,  1'b0});
    pend_q.push_back(pend_t'{101, 1'b1});
    pend_q.push_back(pend_t'{127, 1'b0});
    pend_q.push_back(pend_t'{141, 1'b1});
    pend_q.push_back(pend_t'{159, 1'b0});
    pend_q.push_back(pend_t'{171, 1'b1});
    pend_q.push_back(pend_t'{190, 1'b1});
    pend_q.push_back(pend_t'{191, 1'b0});
    pend_q.push_back(pend_t'{192, 1'b0});
    pend_q.push_back(pend_t'{231, 1'b1});

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkReset("rst0");
    reset_n = 1'b1;
    cyc     = -1;

    // Idle frames 0 and 1 show zeros; 0x12345678 is loaded during digit 3 of frame 1.
    setFrame(NORMAL_ANODES, 32'h0000_0000, 8'hFF);
    runTo(63);
    // Frame 2 shows 8,7,6,5,4,3,2,1 on digits 0..7.
    setFrame(NORMAL_ANODES, 32'h1234_5678, 8'hFF);
    runTo(95);
    // Frame 3: 0x0000A05C with suppression, digits 4..7 dark, dp on digit 2.
    setFrame(64'hFFFF_FFFF_F7FB_FDFE, 32'h0000_A05C, 8'hFB);
    runTo(127);
    // Frame 4: all-zero word with suppression lights digit 0 only.
    setFrame(64'hFFFF_FFFF_FFFF_FFFE, 32'h0000_0000, 8'hFF);
    runTo(159);
    // Frame 5: every digit force-blanked, nibbles still on hex_out.
    setFrame(64'hFFFF_FFFF_FFFF_FFFF, 32'h8765_4321, 8'hFF);
    runTo(191);
    // Frames 6 and early 7: the load coinciding with frame end wins (all 2s).
    setFrame(NORMAL_ANODES, 32'h2222_2222, 8'hFF);
    runTo(245);

    // One-cycle reset during digit 5 with an update pending.
    reset_n = 1'b0;
    tick();
    checkReset("rst1");
    reset_n = 1'b1;
    cyc     = -1;

    // Scan restarts at digit 0 with a zero word; the aborted update never commits.
    setFrame(NORMAL_ANODES, 32'h0000_0000, 8'hFF);
    runTo(39);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sseg_scan_controller.md
Name: sseg_scan_controller

Overview:
- Time-multiplexed scan controller for an 8-digit, common-anode seven-segment display.
- Holds a 32-bit display word and walks one active-low anode per refresh slot.
- Presents the selected nibble on hex_out for the team's combinational hex-to-seven-segment decoder, and drives the matching decimal point.
- Host updates are double-buffered and committed only at frame boundaries, so the display never shows a mix of old and new digits.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot. 100 MHz gives 1 kHz per digit. Legal range is ≥2.
- CNT_W, 17: refresh counter width. Must satisfy 2^CNT_W ≥ REFRESH_DIV.

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- data_in  in  32  display word; nibble k drives digit k (digit 0 is rightmost).
- load  in  1  one-cycle strobe that captures data_in, dp_in, blank_in and lz_en into the pending buffer.
- dp_in  in  8  decimal point per digit, 1 = lit.
- blank_in  in  8  per-digit force-blank, 1 = dark.
- lz_en  in  1  leading-zero suppression enable.
- hex_out  out  4  nibble for the decoder.
- anode  out  8  active-low digit enables.
- dp_n  out  1  active-low decimal point.
- digit_sel  out  3  index of the digit currently driven.
- frame_tick  out  1  one-cycle pulse at the end of digit 7's slot.
- pending  out  1  high while a loaded update awaits commit.

Behaviour:
- Reset, sampled on the clk edge while reset_n = 0:
  - refresh counter = 0, digit_sel = 0.
  - Active and pending buffers = 0; lz_en state = 0.
  - pending = 0, frame_tick = 0, hex_out = 0, anode = 8'hFF, dp_n = 1.
  - Reset mid-frame aborts the scan. The first slot after release is digit 0, with the active word = 0.
- Refresh counter: counts 0 to REFRESH_DIV-1, then wraps to 0.
  - slot_end = (cnt == REFRESH_DIV-1).
  - On slot_end, digit_sel increments modulo 8 (7 wraps to 0).
- frame_end = slot_end with digit_sel == 7. frame_tick is registered and asserted the cycle after frame_end.
- Update handshake:
  - load = 1 captures all inputs into the pending buffer and sets pending = 1.
  - Repeated loads before commit overwrite the buffer; last write wins.
  - On frame_end with pending = 1, the pending buffer copies to the active buffer and pending clears.
  - Simultaneous load and frame_end: the load value from this cycle commits directly to the active buffer and pending ends at 0.
  - frame_end with pending = 0 leaves the active buffer unchanged.
- Leading-zero suppression, evaluated on the active buffer when lz_en is active:
  - Digit k is suppressed if k ≥ 1 and nibbles k..7 are all 0.
  - Digit 0 is never suppressed, so 0x00000000 shows a single "0".
- Digit k is dark if blank_in[k] is active OR it is suppressed.
  - A dark digit gives anode = 8'hFF and dp_n = 1 for the whole slot.
  - hex_out still carries the nibble.
- Output timing:
  - anode, hex_out and dp_n are registered with 1-cycle latency from digit_sel.
  - All three change on the same edge, one cycle after digit_sel changes. No intra-slot glitching.
- Lit digit k: anode = ~(8'b1 << k), hex_out = active[4k+3:4k], dp_n = ~dp[k].
- Exactly zero or one anode bit is low in any cycle.

Test Plan (REFRESH_DIV = 4):
1. Reset, then idle for 40 cycles.
   - anode sequences FE, FD, FB, F7, EF, DF, BF, 7F, FE, each held 4 cycles.
   - hex_out = 0 throughout; frame_tick pulses every 32 cycles.
2. Load 0x12345678 mid-frame (digit 3).
   - pending = 1 until frame_end.
   - The current frame still shows 0s.
   - The next frame shows hex_out 8, 7, 6, 5, 4, 3, 2, 1 for digits 0–7; pending = 0.
3. Load 0x0000A05C with lz_en = 1, dp_in = 8'h04.
   - Digits 4–7 are dark (anode FF).
   - Digits 0–3 are lit with C, 5, 0, A.
   - dp_n = 0 only during digit 2.
4. Load 0 with lz_en = 1.
   - Only digit 0 lights, with hex_out = 0.
   - Then load blank_in = 8'hFF: anode stays FF for the entire next frame.
5. Two loads (0x11111111, then 0x22222222) in one frame, with the second coinciding with frame_end.
   - The next frame shows all 2s; pending = 0 immediately after.
6. Assert reset_n = 0 for 1 cycle during digit 5 after a committed value.
   - Outputs return to reset values; scan restarts at digit 0 showing 0s; pending = 0.
